pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequences the PC and the IF/ID, ID/EX and EX/MEM pipeline registers of the RV32 core.
//  Drives their en/clear inputs and the IF/ID pc_valid input, and redirects the PC.
//  Resolves three hazards: data-memory stall, EX-stage branch/jump redirect, and load-use.
//  Counts stall and flush events for performance debug.
// PARAMETERS
//  SQUASH_CYCLES  1   fetch latency; cycles after a redirect in which fetched words are marked invalid (0..15)
//  CNT_W          32  width of the saturating performance counters
// PORTS
//  clk                 in   1   clock, all state updates on rising edge
//  rst                 in   1   synchronous reset, active-high
//  id_valid_i          in   1   IF/ID holds a valid instruction
//  id_rs1_i            in   5   rs1 index of the instruction in ID
//  id_rs2_i            in   5   rs2 index of the instruction in ID
//  id_use_rs1_i        in   1   ID instruction reads rs1
//  id_use_rs2_i        in   1   ID instruction reads rs2
//  ex_valid_i          in   1   ID/EX holds a valid instruction
//  ex_mem_read_i       in   1   EX instruction is a load
//  ex_rd_i             in   5   EX destination register
//  ex_redirect_i       in   1   EX resolved a misprediction (taken != predicted, or wrong target)
//  ex_target_i         in   32  correct next PC from EX
//  dmem_busy_i         in   1   MEM stage waiting on data memory
//  pc_en_o             out  1   PC register enable
//  pc_redirect_o       out  1   PC mux selects pc_target_o
//  pc_target_o         out  32  redirect PC
//  fetch_valid_o       out  1   drives IF/ID pc_valid_i
//  if_id_en_o / if_id_clear_o     out 1 each  IF/ID enable / clear
//  id_ex_en_o / id_ex_clear_o     out 1 each  ID/EX enable / clear
//  ex_mem_en_o / ex_mem_clear_o   out 1 each  EX/MEM enable / clear
//  stall_cnt_o         out  CNT_W  cycles with pc_en_o=0 (saturating)
//  flush_cnt_o         out  CNT_W  redirects taken (saturating)
// BEHAVIOUR
//  FSM states: RUN, SQUASH. A 4-bit squash counter is used in SQUASH.
//  Reset (rst=1): state=RUN, counters=0. Outputs while rst=1: all *_en_o=0, all *_clear_o=1,
//    pc_redirect_o=0, fetch_valid_o=0. Reset mid-SQUASH abandons the squash.
//  All en/clear/redirect outputs are combinational from the inputs and state; take effect the same cycle.
//  Hazard terms:
//    lu = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & ((use_rs1 & rs1==ex_rd) | (use_rs2 & rs2==ex_rd))
//  Priority, highest first:
//  1 dmem_busy_i: all en=0, all clear=0, pc_redirect=0. Whole pipe is frozen; state and counter are held.
//    ex_redirect_i is ignored and must stay asserted, because EX is frozen.
//  2 ex_redirect_i: pc_en=1, pc_redirect=1, pc_target=ex_target_i, if_id_clear=1, id_ex_clear=1, ex_mem_en=1.
//    Next state: SQUASH with counter=SQUASH_CYCLES, or RUN if SQUASH_CYCLES=0.
//    flush_cnt increments. Overrides lu. A redirect in SQUASH restarts the counter.
//  3 lu: pc_en=0, if_id_en=0, id_ex_clear=1 (bubble), ex_mem_en=1. Single-cycle stall.
//  4 otherwise: all en=1, all clear=0.
//  fetch_valid_o = 0 in SQUASH and in the redirect cycle; otherwise 1.
//  SQUASH: the counter decrements on each non-busy cycle; at 1 -> RUN.
//  When a clear and an en are both asserted, clear wins (pipeline-register rule).
//  stall_cnt increments on every non-reset cycle with pc_en_o=0. Both counters saturate at all-ones.
// TESTING
//  1 rst=1 for 2 cycles -> all clears=1, ens=0, fetch_valid=0; after release, RUN with all ens=1 and counters=0.
//  2 Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, use_rs1=1 -> exactly 1 cycle with pc_en=0, if_id_en=0,
//    id_ex_clear=1; stall_cnt=1.
//  3 Load-use with ex_rd=0, or use_rs1=0 -> no stall.
//  4 ex_redirect=1, target=0x0000_0100, SQUASH_CYCLES=2 -> pc_redirect=1, pc_target=0x100, IF/ID and ID/EX cleared;
//    fetch_valid=0 for the redirect cycle plus 2 cycles, then 1; flush_cnt=1.
//  5 dmem_busy=1 for 3 cycles together with ex_redirect=1 and lu=1 -> all en=0 for 3 cycles;
//    then the redirect fires (not lu); stall_cnt=3.
//  6 CNT_W=4: 20 load-use stalls -> stall_cnt holds at 0xF.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the RV32 pipeline: drives PC/IF-ID/ID-EX/EX-MEM enable and clear,
// PC redirect and fetch-valid, and keeps saturating stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int SQUASH_CYCLES = 1,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic             ex_valid_i,
    input  logic             ex_mem_read_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_redirect_i,
    input  logic [31:0]      ex_target_i,
    input  logic             dmem_busy_i,
    output logic             pc_en_o,
    output logic             pc_redirect_o,
    output logic [31:0]      pc_target_o,
    output logic             fetch_valid_o,
    output logic             if_id_en_o,
    output logic             if_id_clear_o,
    output logic             id_ex_en_o,
    output logic             id_ex_clear_o,
    output logic             ex_mem_en_o,
    output logic             ex_mem_clear_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } state_t;

    localparam logic [3:0] SQ_INIT = 4'(SQUASH_CYCLES);

    state_t           r_state;
    logic [3:0]       r_sq_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_lu;
    logic w_redirect;
    logic w_squash;

    assign w_lu = ex_valid_i && ex_mem_read_i && (ex_rd_i != 5'd0) && id_valid_i &&
                  ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                   (id_use_rs2_i && (id_rs2_i == ex_rd_i)));
    // EX is frozen while memory is busy, so a pending redirect only fires once busy drops
    assign w_redirect = ex_redirect_i && !dmem_busy_i;
    assign w_squash   = (r_state == ST_SQUASH);

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

    // Same-cycle pipeline control, resolved in priority order
    always_comb begin
        pc_en_o        = 1'b1;
        pc_redirect_o  = 1'b0;
        pc_target_o    = 32'h0000_0000;
        fetch_valid_o  = !w_squash;
        if_id_en_o     = 1'b1;
        if_id_clear_o  = 1'b0;
        id_ex_en_o     = 1'b1;
        id_ex_clear_o  = 1'b0;
        ex_mem_en_o    = 1'b1;
        ex_mem_clear_o = 1'b0;
        if (rst) begin
            pc_en_o        = 1'b0;
            fetch_valid_o  = 1'b0;
            if_id_en_o     = 1'b0;
            if_id_clear_o  = 1'b1;
            id_ex_en_o     = 1'b0;
            id_ex_clear_o  = 1'b1;
            ex_mem_en_o    = 1'b0;
            ex_mem_clear_o = 1'b1;
        end else if (dmem_busy_i) begin
            pc_en_o     = 1'b0;
            if_id_en_o  = 1'b0;
            id_ex_en_o  = 1'b0;
            ex_mem_en_o = 1'b0;
        end else if (ex_redirect_i) begin
            pc_redirect_o = 1'b1;
            pc_target_o   = ex_target_i;
            fetch_valid_o = 1'b0;
            if_id_clear_o = 1'b1;
            id_ex_clear_o = 1'b1;
        end else if (w_lu) begin
            pc_en_o       = 1'b0;
            if_id_en_o    = 1'b0;
            id_ex_clear_o = 1'b1;
        end else begin
            pc_en_o = 1'b1;
        end
    end

    // Squash sequencing and saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_sq_cnt    <= 4'd0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!pc_en_o && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (dmem_busy_i) begin
                r_state  <= r_state;
                r_sq_cnt <= r_sq_cnt;
            end else if (w_redirect) begin
                if (r_flush_cnt != {CNT_W{1'b1}}) begin
                    r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                if (SQ_INIT == 4'd0) begin
                    r_state  <= ST_RUN;
                    r_sq_cnt <= 4'd0;
                end else begin
                    r_state  <= ST_SQUASH;
                    r_sq_cnt <= SQ_INIT;
                end
            end else begin
                case (r_state)
                    ST_SQUASH: begin
                        if (r_sq_cnt <= 4'd1) begin
                            r_state  <= ST_RUN;
                            r_sq_cnt <= 4'd0;
                        end else begin
                            r_sq_cnt <= r_sq_cnt - 4'd1;
                        end
                    end
                    ST_RUN: begin
                        r_sq_cnt <= 4'd0;
                    end
                    default: begin
                        r_state  <= ST_RUN;
                        r_sq_cnt <= 4'd0;
                    end
                endcase
            end
        end
    end

endmodule
